conv_parallel_sequencer: RTL and testbench
==========================================

// Module: conv_parallel_sequencer
// PURPOSE
//  Runtime-configurable column sequencer for one convolution unit. It walks every
//  parallel segment of a row and emits one input-column position per handshake, with
//  segment index, output-enable (valid conv output, stride-aligned) and last flags.
//  Generalises the fixed per-unit parallel/stride tables: segment count, pitch, length
//  and stride are loaded per layer. Sits between the layer controller and the conv unit.
// PARAMETERS
//  COL_MAX  = 32  max columns per row (conv size + padding); col width CW=$clog2(COL_MAX)
//  KER_MAX  = 7   max kernel size supported
//  PAR_MAX  = 6   max parallel segments per row
//  STR_MAX  = 4   max stride
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          async active-low reset
//  cfg_start    in   1          start pulse; config sampled only when accepted (IDLE)
//  cfg_seg_num  in   clog2(PAR_MAX+1)  number of segments n (0..PAR_MAX)
//  cfg_pitch    in   CW         column distance between segment starts
//  cfg_len      in   CW+1       input columns per segment (1..COL_MAX)
//  cfg_ker      in   clog2(KER_MAX+1)  kernel size K
//  cfg_stride   in   clog2(STR_MAX+1)  stride S (0 treated as 1)
//  abort        in   1          sync clear to IDLE, highest priority after reset
//  pos_valid    out  1          position beat valid
//  pos_ready    in   1          consumer ready
//  pos_col      out  CW         absolute input column
//  pos_seg      out  clog2(PAR_MAX) segment index
//  pos_out_en   out  1          this column completes a stored conv output
//  pos_last     out  1          final beat of the row
//  busy         out  1          high in LOAD/RUN
//  done         out  1          one-cycle pulse at end of row
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal counters 0.
//  FSM IDLE -> LOAD on cfg_start; LOAD -> RUN (1 cycle, computes segment bounds);
//    RUN -> DONE after handshake of beat with pos_last; DONE -> IDLE (1 cycle, done=1).
//  cfg_start outside IDLE ignored. cfg_seg_num=0 or cfg_len=0: LOAD -> DONE, no beats.
//  Segment k: in_start=k*pitch, cols in_start..in_start+len-1 emitted in order, k=0..n-1.
//  Column index r = col-in_start. pos_out_en = (r+K <= len) && (r mod S == 0).
//    len < K: segment emits all columns, pos_out_en never set.
//  Columns with col >= COL_MAX are skipped (not emitted); a segment entirely beyond
//    COL_MAX is skipped; pos_last marks the last emitted beat overall.
//  Handshake: beat transfers when pos_valid & pos_ready. While pos_valid=1 and not
//    ready, all pos_* held stable. pos_valid may assert without waiting for ready.
//  Throughput: one beat/cycle under continuous ready; first beat valid 2 cycles after
//    accepted cfg_start (LOAD, then RUN).
//  Stride modulo via down-counter reloaded to S-1 at each segment start; no divider.
//  abort: next cycle state=IDLE, pos_valid=0, busy=0, done not pulsed. abort and
//    cfg_start in same cycle: abort wins, start dropped.
//  Async reset mid-row: immediate return to reset values; no done.
// TESTING
//  1) n=1,pitch=0,len=31,K=5,S=1 -> 31 beats col 0..30, out_en on 0..26, last on 30, done once.
//  2) n=2,pitch=14,len=14,K=5,S=1 -> cols 0..13 seg0, 14..27 seg1; out_en 0..9 and 14..23.
//  3) n=6,pitch=6,len=5,K=5,S=1 -> out_en only cols 0,6,12,18,24,30; seg 0..5; last at col 31? no: col 34 skipped, last=col 31 (COL_MAX=32).
//  4) n=1,len=12,K=3,S=2 with ready toggling 1010.. -> out_en cols 0,2,4,6,8; outputs stable when stalled.
//  5) abort asserted at 3rd beat of case 1 -> pos_valid=0 next cycle, no done; new start runs clean.
//  6) cfg_seg_num=0 -> busy 1 cycle, done pulse, zero beats; cfg_start during RUN ignored.

Source files
------------

// File: rtl/conv_parallel_sequencer.sv
// Column sequencer for one convolution unit. It walks every parallel segment of
// a row and emits one input-column position per valid/ready beat. Each beat
// carries the segment index, an output-enable flag (the column completes a
// stride-aligned conv output) and a last flag. Segment count, pitch, length,
// kernel and stride are loaded per layer on cfg_start.
//
// Handshake: a beat transfers on a cycle where pos_valid & pos_ready are both
// high at the rising clock edge. pos_valid is raised without waiting for
// pos_ready, and while pos_valid is high and pos_ready is low every pos_*
// output is held stable.
module conv_parallel_sequencer #(
  parameter int COL_MAX = 32,
  parameter int KER_MAX = 7,
  parameter int PAR_MAX = 6,
  parameter int STR_MAX = 4,
  localparam int CW = $clog2(COL_MAX),
  localparam int NW = $clog2(PAR_MAX + 1),
  localparam int SW = $clog2(PAR_MAX),
  localparam int KW = $clog2(KER_MAX + 1),
  localparam int TW = $clog2(STR_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic [NW-1:0] cfg_seg_num,
  input  logic [CW-1:0] cfg_pitch,
  input  logic [CW:0]   cfg_len,
  input  logic [KW-1:0] cfg_ker,
  input  logic [TW-1:0] cfg_stride,
  input  logic          abort,
  output logic          pos_valid,
  input  logic          pos_ready,
  output logic [CW-1:0] pos_col,
  output logic [SW-1:0] pos_seg,
  output logic          pos_out_en,
  output logic          pos_last,
  output logic          busy,
  output logic          done,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Configuration captured when a start is accepted in IDLE.
  logic [NW-1:0] n_q;
  logic [CW-1:0] pitch_q;
  logic [CW:0]   len_q;
  logic [KW-1:0] ker_q;
  logic [TW-1:0] stride_q;

  // Derived in LOAD: stride-1 (stride 0 acts as 1) and the last column
  // index r that still leaves a full kernel window inside the segment.
  logic [TW-1:0] s_m1_q;
  logic          oe_ok_q;
  logic [CW:0]   oe_lim_q;

  // Walk position: segment index, segment start, absolute column, column
  // index within the segment and the stride phase down-counter.
  logic [SW-1:0] seg_q;
  logic [CW-1:0] start_q;
  logic [CW-1:0] col_q;
  logic [CW-1:0] r_q;
  logic [TW-1:0] scnt_q;

  logic [TW-1:0] s_m1_w;
  logic [CW:0]   col_inc;
  logic [CW:0]   r_inc;
  logic [CW:0]   next_start;
  logic [NW:0]   seg_inc;
  logic          same_seg;
  logic          next_seg;
  logic          is_last;
  logic          fire;
  logic          run;

  assign s_m1_w     = (stride_q == '0) ? '0 : stride_q - TW'(1);
  assign col_inc    = {1'b0, col_q} + (CW+1)'(1);
  assign r_inc      = {1'b0, r_q} + (CW+1)'(1);
  assign next_start = {1'b0, start_q} + {1'b0, pitch_q};
  assign seg_inc    = (NW+1)'(seg_q) + (NW+1)'(1);

  // Another column of this segment exists if the segment is not exhausted
  // and the column stays inside the row. Segment starts never decrease, so
  // once the next start falls past the row every later segment does too.
  assign same_seg = (r_inc < len_q) && (col_inc < (CW+1)'(COL_MAX));
  assign next_seg = (seg_inc < (NW+1)'(n_q)) && (next_start < (CW+1)'(COL_MAX));
  assign is_last  = !same_seg && !next_seg;

  assign run  = (state_q == RUN);
  assign fire = run && pos_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition including a start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cfg_start) state_d = LOAD;
      LOAD: begin
        if (n_q == '0 || len_q == '0) state_d = DONE;
        else                          state_d = RUN;
      end
      RUN:  if (fire && is_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Config capture, per-layer precompute and the column walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      pitch_q  <= '0;
      len_q    <= '0;
      ker_q    <= '0;
      stride_q <= '0;
      s_m1_q   <= '0;
      oe_ok_q  <= 1'b0;
      oe_lim_q <= '0;
      seg_q    <= '0;
      start_q  <= '0;
      col_q    <= '0;
      r_q      <= '0;
      scnt_q   <= '0;
    end else if (abort) begin
      seg_q   <= '0;
      start_q <= '0;
      col_q   <= '0;
      r_q     <= '0;
      scnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            n_q      <= cfg_seg_num;
            pitch_q  <= cfg_pitch;
            len_q    <= cfg_len;
            ker_q    <= cfg_ker;
            stride_q <= cfg_stride;
          end
        end
        LOAD: begin
          s_m1_q   <= s_m1_w;
          oe_ok_q  <= (len_q >= (CW+1)'(ker_q));
          oe_lim_q <= len_q - (CW+1)'(ker_q);
          seg_q    <= '0;
          start_q  <= '0;
          col_q    <= '0;
          r_q      <= '0;
          scnt_q   <= s_m1_w;
        end
        RUN: begin
          if (fire && !is_last) begin
            if (same_seg) begin
              col_q  <= col_inc[CW-1:0];
              r_q    <= r_inc[CW-1:0];
              scnt_q <= (scnt_q == '0) ? s_m1_q : scnt_q - TW'(1);
            end else begin
              seg_q   <= seg_inc[SW-1:0];
              start_q <= next_start[CW-1:0];
              col_q   <= next_start[CW-1:0];
              r_q     <= '0;
              scnt_q  <= s_m1_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Beat outputs come straight from the walk registers, which only move on
  // a transfer, so they stay put while the consumer stalls. A column index
  // is stride-aligned when the phase counter sits at its reload value.
  assign pos_valid  = run;
  assign pos_col    = run ? col_q : '0;
  assign pos_seg    = run ? seg_q : '0;
  assign pos_out_en = run && oe_ok_q && ((CW+1)'(r_q) <= oe_lim_q) && (scnt_q == s_m1_q);
  assign pos_last   = run && is_last;
  assign busy       = (state_q == LOAD) || run;
  assign done       = (state_q == DONE);
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_conv_parallel_sequencer.sv
// Bench for conv_parallel_sequencer: a reference walk of the row fills an
// expected queue of beats, a monitor pops and compares on every transfer.
module tb_conv_parallel_sequencer;

  localparam int COL_MAX = 32;
  localparam int CW = 5;
  localparam int NW = 3;
  localparam int SW = 3;
  localparam int KW = 3;
  localparam int TW = 3;
  localparam int BW = CW + SW + 2;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_start = 1'b0;
  logic [NW-1:0] cfg_seg_num = '0;
  logic [CW-1:0] cfg_pitch = '0;
  logic [CW:0]   cfg_len = '0;
  logic [KW-1:0] cfg_ker = '0;
  logic [TW-1:0] cfg_stride = '0;
  logic          abort = 1'b0;
  logic          pos_ready = 1'b0;
  logic          pos_valid;
  logic [CW-1:0] pos_col;
  logic [SW-1:0] pos_seg;
  logic          pos_out_en;
  logic          pos_last;
  logic          busy;
  logic          done;
  logic [1:0]    fsm_state;

  conv_parallel_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_seg_num (cfg_seg_num),
    .cfg_pitch   (cfg_pitch),
    .cfg_len     (cfg_len),
    .cfg_ker     (cfg_ker),
    .cfg_stride  (cfg_stride),
    .abort       (abort),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .pos_col     (pos_col),
    .pos_seg     (pos_seg),
    .pos_out_en  (pos_out_en),
    .pos_last    (pos_last),
    .busy        (busy),
    .done        (done),
    .fsm_state   (fsm_state)
  );

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int beats_seen = 0;
  int rdy_mode = 0;
  logic rdy_tog = 1'b0;

  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference walk: every column of every segment, dropping those past the row.
  task automatic build_expect(input int n, input int pitch, input int len, input int k, input int s);
    int se;
    int col;
    logic oe;
    logic [BW-1:0] b;
    se = (s == 0) ? 1 : s;
    exp_q.delete();
    for (int seg = 0; seg < n; seg++) begin
      for (int r = 0; r < len; r++) begin
        col = seg * pitch + r;
        if (col < COL_MAX) begin
          oe = ((r + k) <= len) && ((r % se) == 0);
          b = {col[CW-1:0], seg[SW-1:0], oe, 1'b0};
          exp_q.push_back(b);
        end
      end
    end
    if (exp_q.size() > 0) begin
      b = exp_q.pop_back();
      b[0] = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Consumer ready pattern: 0 = always, 1 = toggling, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy_tog = ~rdy_tog;
      case (rdy_mode)
        0: pos_ready = 1'b1;
        1: pos_ready = rdy_tog;
        default: pos_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (pos_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          check(pos_ready ? "beat" : "stall_hold",
                32'({pos_col, pos_seg, pos_out_en, pos_last}), 32'(exp_q[0]));
          if (pos_ready) begin
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end
    end
  end

  task automatic set_cfg(input int n, input int pitch, input int len, input int k, input int s);
    cfg_seg_num = NW'(n);
    cfg_pitch   = CW'(pitch);
    cfg_len     = (CW+1)'(len);
    cfg_ker     = KW'(k);
    cfg_stride  = TW'(s);
  endtask

  task automatic run_case(input int n, input int pitch, input int len, input int k,
                          input int s, input int mode, input bit poke);
    int nbeats;
    build_expect(n, pitch, len, k, s);
    nbeats = exp_q.size();
    rdy_mode = mode;
    done_cnt = 0;
    beats_seen = 0;
    set_cfg(n, pitch, len, k, s);
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    // Scramble the config inputs: only the accepted sample may matter.
    set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 32)), int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
    @(negedge clk);
    check("load_busy", 32'(busy), 32'd1);
    check("load_valid", 32'(pos_valid), 32'd0);
    @(negedge clk);
    check("first_valid", 32'(pos_valid), 32'(nbeats > 0));
    if (nbeats == 0) begin
      check("empty_done", 32'(done), 32'd1);
      check("empty_busy", 32'(busy), 32'd0);
    end
    if (poke) begin
      @(posedge clk); #1 cfg_start = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b0;
    end
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_once", 32'(done_cnt), 32'd1);
    check("beat_count", 32'(beats_seen), 32'(nbeats));
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  // Main sequence.
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(pos_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_beat", 32'({pos_col, pos_seg, pos_out_en, pos_last}), 32'd0);
    check("reset_state", 32'(fsm_state), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_case(1, 0, 31, 5, 1, 0, 1'b0);
    run_case(2, 14, 14, 5, 1, 2, 1'b1);
    run_case(6, 6, 5, 5, 1, 0, 1'b0);
    run_case(1, 0, 12, 3, 2, 1, 1'b0);
    run_case(0, 4, 5, 3, 1, 0, 1'b0);
    run_case(2, 3, 0, 3, 1, 0, 1'b0);
    run_case(2, 20, 3, 5, 0, 2, 1'b0);
    run_case(4, 9, 10, 3, 3, 2, 1'b1);
    run_case(3, 31, 7, 2, 4, 1, 1'b0);

    // Abort while the third beat of a row is on the bus.
    build_expect(1, 0, 31, 5, 1);
    rdy_mode = 0;
    done_cnt = 0;
    beats_seen = 0;
    set_cfg(1, 0, 31, 5, 1);
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(pos_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(fsm_state), 32'd0);
    repeat (4) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_beats", 32'(beats_seen), 32'd3);
    exp_q.delete();
    run_case(1, 0, 31, 5, 1, 0, 1'b0);

    // Abort and start together: the start is dropped.
    @(posedge clk); #1 begin abort = 1'b1; cfg_start = 1'b1; end
    @(posedge clk); #1 begin abort = 1'b0; cfg_start = 1'b0; end
    @(negedge clk);
    check("abort_wins", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a row.
    build_expect(2, 14, 14, 5, 1);
    rdy_mode = 0;
    done_cnt = 0;
    set_cfg(2, 14, 14, 5, 1);
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(pos_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_col", 32'(pos_col), 32'd0);
    exp_q.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_no_done", 32'(done_cnt), 32'd0);
    run_case(3, 10, 12, 4, 2, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    check("time_limit", 32'd1, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
